// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Define CLA_OVF_EN to add the registered signed-overflow output out_ovf.
`timescale 1ns/1ps
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int GPS   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef CLA_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int STAGES = WIDTH / (4 * GPS);

  generate
    if (GPS < 1 || WIDTH < 4 * GPS || (WIDTH % (4 * GPS)) != 0) begin : g_bad_width
      $error("cla_pipe_adder: WIDTH must be a positive multiple of 4*GPS");
    end
  endgenerate

  // One 4-bit lookahead group: returns {G, P, sum[3:0]} with every carry expanded from c0.
  function automatic logic [5:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                      input logic c0);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;
    logic       grp_g;
    logic       grp_p;
    g     = a & b;
    p     = a ^ b;
    c[0]  = c0;
    c[1]  = g[0] | (p[0] & c0);
    c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    grp_p = &p;
    return {grp_g, grp_p, p ^ c};
  endfunction

  logic [WIDTH-1:0] a_d     [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] b_d     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic [WIDTH-1:0] sum_d   [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];
  logic             carry_d [STAGES];
  logic             carry_q [STAGES];
  logic             valid_d [STAGES];
  logic             valid_q [STAGES];
`ifdef CLA_OVF_EN
  logic             ovf_d;
  logic             ovf_q;
`endif

  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic             adv;

  always_comb begin : cond_comb
    b_eff    = in_sub ? ~in_b : in_b;
    c0       = in_sub | in_cin;
    adv      = ~valid_q[STAGES-1] | out_ready;
    in_ready = adv & rst_n;
  end

  // Stage k resolves groups k*GPS..(k+1)*GPS-1 from the previous stage's registers.
  always_comb begin : stage_comb
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] src_sum;
    logic             src_c;
    logic             src_v;
    logic             c;
    logic [5:0]       grp;
    int               lsb;
    int               prev;
`ifdef CLA_OVF_EN
    ovf_d = 1'b0;
`endif
    for (int k = 0; k < STAGES; k++) begin
      prev = (k > 0) ? k - 1 : 0;
      if (k == 0) begin
        src_a   = in_a;
        src_b   = b_eff;
        src_sum = '0;
        src_c   = c0;
        src_v   = in_valid;
      end else begin
        src_a   = a_q[prev];
        src_b   = b_q[prev];
        src_sum = sum_q[prev];
        src_c   = carry_q[prev];
        src_v   = valid_q[prev];
      end
      c = src_c;
      for (int j = 0; j < GPS; j++) begin
        lsb                = (k * GPS + j) * 4;
        grp                = cla4(src_a[lsb +: 4], src_b[lsb +: 4], c);
        src_sum[lsb +: 4]  = grp[3:0];
        c                  = grp[5] | (grp[4] & c);
      end
      a_d[k]     = src_a;
      b_d[k]     = src_b;
      sum_d[k]   = src_sum;
      carry_d[k] = c;
      valid_d[k] = src_v;
`ifdef CLA_OVF_EN
      if (k == STAGES - 1) begin
        ovf_d = (src_a[WIDTH-1] == src_b[WIDTH-1]) & (src_sum[WIDTH-1] != src_a[WIDTH-1]);
      end
`endif
    end
  end

  // Data fields load only behind a valid bit, so bubbles never disturb held results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        carry_q[k] <= 1'b0;
        sum_q[k]   <= '0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
      end
`ifdef CLA_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        if (valid_d[k]) begin
          carry_q[k] <= carry_d[k];
          sum_q[k]   <= sum_d[k];
          a_q[k]     <= a_d[k];
          b_q[k]     <= b_d[k];
        end
      end
`ifdef CLA_OVF_EN
      if (valid_d[STAGES-1]) begin
        ovf_q <= ovf_d;
      end
`endif
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign out_sum   = sum_q[STAGES-1];
  assign out_cout  = carry_q[STAGES-1];
`ifdef CLA_OVF_EN
  assign out_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: directed vectors on a GPS=1 instance plus a GPS=2 latency check.
`timescale 1ns/1ps
module tb_cla_pipe_adder;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          acc_cyc;
    int          lat;
    int          id;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_cin;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        in_valid2;
  logic        in_ready2;
  logic        out_valid2;
  logic        out_ready2;
  logic [15:0] out_sum2;
  logic        out_cout2;
`ifdef CLA_OVF_EN
  logic        out_ovf;
  logic        out_ovf2;
`endif

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   head_seen = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cla_pipe_adder #(.WIDTH(16), .GPS(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout)
`ifdef CLA_OVF_EN
    , .out_ovf(out_ovf)
`endif
  );

  cla_pipe_adder #(.WIDTH(16), .GPS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_sum(out_sum2), .out_cout(out_cout2)
`ifdef CLA_OVF_EN
    , .out_ovf(out_ovf2)
`endif
  );

  task automatic checkOutput(input string name, input int id, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s (id %0d): got %0h expected %0h", name, id, act, exp);
    end
  endtask

  // Called just after a negedge; returns at the negedge following the accept edge.
  task automatic applyStimulus(input int id, input logic [15:0] a, input logic [15:0] b,
                               input logic cin, input logic sub, input logic [15:0] esum,
                               input logic ecout, input logic eovf, input int lat);
    exp_t e;
    int   n;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
    n        = 0;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", id, 32'(in_ready), 32'd1);
    end else begin
      e.sum     = esum;
      e.cout    = ecout;
      e.ovf     = eovf;
      e.acc_cyc = cyc + 1;
      e.lat     = lat;
      e.id      = id;
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic waitDrain(input int id);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", id, 32'(sb.size()), 32'd0);
  endtask

  // Monitor: compares the head of the scoreboard whenever a result retires.
  initial begin
    exp_t h;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid) begin
        if (sb.size() == 0) begin
          checkOutput("spurious_valid", -1, 32'(out_valid), 32'd0);
        end else begin
          h = sb[0];
          if (!head_seen) begin
            head_seen = 1;
            if (h.lat != 0) checkOutput("latency", h.id, 32'(cyc - h.acc_cyc + 1), 32'(h.lat));
          end
          if (out_ready) begin
            void'(sb.pop_front());
            head_seen = 0;
            checkOutput("sum", h.id, 32'(out_sum), 32'(h.sum));
            checkOutput("cout", h.id, 32'(out_cout), 32'(h.cout));
`ifdef CLA_OVF_EN
            checkOutput("ovf", h.id, 32'(out_ovf), 32'(h.ovf));
`endif
          end
        end
      end
    end
  end

  initial begin
    int lat2;
    rst_n      = 1'b0;
    in_valid   = 1'b1;
    in_a       = 16'h1234;
    in_b       = 16'h4321;
    in_cin     = 1'b0;
    in_sub     = 1'b0;
    out_ready  = 1'b1;
    in_valid2  = 1'b0;
    out_ready2 = 1'b1;

    // Reset held two cycles with in_valid asserted.
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst_out_valid", 0, 32'(out_valid), 32'd0);
    checkOutput("rst_out_sum", 0, 32'(out_sum), 32'h0000);
    checkOutput("rst_out_cout", 0, 32'(out_cout), 32'd0);
    checkOutput("rst_in_ready", 0, 32'(in_ready), 32'd0);
`ifdef CLA_OVF_EN
    checkOutput("rst_out_ovf", 0, 32'(out_ovf), 32'd0);
`endif
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("post_rst_in_ready", 0, 32'(in_ready), 32'd1);
    checkOutput("post_rst_out_valid", 0, 32'(out_valid), 32'd0);

    // Full carry chain, subtract pair, carry-in ripple.
    @(negedge clk);
    applyStimulus(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4);
    applyStimulus(2, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 4);
    applyStimulus(3, 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 4);
    applyStimulus(4, 16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 4);
    idle();
    waitDrain(4);

    // Same full carry chain on the GPS=2 instance: two stages.
    @(negedge clk);
    in_a      = 16'hFFFF;
    in_b      = 16'h0001;
    in_cin    = 1'b0;
    in_sub    = 1'b0;
    in_valid2 = 1'b1;
    #1;
    checkOutput("gps2_in_ready", 20, 32'(in_ready2), 32'd1);
    @(negedge clk);
    in_valid2 = 1'b0;
    lat2 = 1;
    #2;
    while (!out_valid2 && lat2 < 10) begin
      @(negedge clk);
      #2;
      lat2++;
    end
    checkOutput("gps2_latency", 20, 32'(lat2), 32'd2);
    checkOutput("gps2_sum", 20, 32'(out_sum2), 32'h0000);
    checkOutput("gps2_cout", 20, 32'(out_cout2), 32'd1);

    // Backpressure: four adds fill the pipe while the output is blocked.
    @(negedge clk);
    out_ready = 1'b0;
    applyStimulus(5, 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 4);
    applyStimulus(6, 16'h0002, 16'h0002, 1'b0, 1'b0, 16'h0004, 1'b0, 1'b0, 0);
    applyStimulus(7, 16'h0003, 16'h0003, 1'b0, 1'b0, 16'h0006, 1'b0, 1'b0, 0);
    applyStimulus(8, 16'h0004, 16'h0004, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b0, 0);
    in_a = 16'h0009;
    in_b = 16'h0009;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("stall_out_valid", 5, 32'(out_valid), 32'd1);
      checkOutput("stall_out_sum", 5, 32'(out_sum), 32'h0002);
      checkOutput("stall_in_ready", 5, 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    // Retire and accept in the same cycle with a full pipe.
    out_ready = 1'b1;
    applyStimulus(9, 16'h0005, 16'h0005, 1'b0, 1'b0, 16'h000A, 1'b0, 1'b0, 0);
    idle();
    waitDrain(9);

    // Reset mid-flight discards both accepted transactions.
    @(negedge clk);
    applyStimulus(10, 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 0);
    applyStimulus(11, 16'h3333, 16'h4444, 1'b0, 1'b0, 16'h7777, 1'b0, 1'b0, 0);
    idle();
    rst_n = 1'b0;
    sb.delete();
    head_seen = 0;
    #1;
    checkOutput("midrst_in_ready", 10, 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      checkOutput("midrst_out_valid", 10, 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    applyStimulus(12, 16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0, 4);
    idle();
    waitDrain(12);

    // Signed overflow boundaries.
    @(negedge clk);
    applyStimulus(13, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 4);
    applyStimulus(14, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 4);
    applyStimulus(15, 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 4);
    applyStimulus(16, 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 4);
    idle();
    waitDrain(16);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor and the successor to the 4-bit combinational CLA.
- Operand width is split into 4-bit lookahead groups. GPS groups are resolved per pipeline stage, and the inter-stage carry is registered.
- Valid/ready handshake at both ends, so the block can sit directly in an arithmetic datapath with backpressure.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4*GPS; otherwise elaboration fails.
- GPS, 1, 4-bit groups per pipeline stage. STAGES = WIDTH/(4*GPS).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input operands valid
- in_ready  out  1  block accepts operands this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_cin  in  1  carry-in (add mode only)
- in_sub  in  1  1 = compute A - B
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_sum  out  WIDTH  result
- out_cout  out  1  carry-out (in subtract mode: 1 = no borrow)
- out_ovf  out  1  signed overflow (CLA_OVF_EN only)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Operand conditioning at accept:
  - b_eff = in_sub ? ~in_b : in_b
  - c0 = in_sub ? 1 : in_cin
- Per bit: g = a & b_eff, p = a ^ b_eff, sum = p ^ c.
- Within a 4-bit group, carries are fully expanded lookahead from the group carry-in, e.g. c2 = g1 | p1g0 | p1p0c0.
- Each group forms group G/P. Group carries within one stage ripple through G | P·cin.
- Pipeline: stage k computes groups k*GPS .. (k+1)*GPS-1 and registers:
  - those sum bits;
  - stage carry-out;
  - the still-unprocessed operand bits;
  - the sign bits needed for overflow;
  - a valid bit.
- The final stage register drives out_sum, out_cout, out_ovf and out_valid.
- Latency: exactly STAGES cycles from accept (in_valid & in_ready at edge) to out_valid high. Throughput is 1 per cycle when out_ready is held high.
- Advance rule: adv = ~out_valid | out_ready.
  - in_ready = adv & rst_n.
  - On adv, all stages shift by one. Stage 0 loads valid = in_valid.
  - Bubbles move through like data. Pipeline does not collapse bubbles.
- Stall (out_valid & ~out_ready): every stage register holds. out_sum, out_cout and out_ovf stay stable. in_ready = 0. No transaction is lost or duplicated.
- Order is strictly preserved.
- Simultaneous out_ready and in_valid with a full pipeline: output retires and input is accepted in the same cycle.
- Reset (rst_n low at a clock edge):
  - all valid bits = 0, out_valid = 0, out_sum = 0, out_cout = 0, out_ovf = 0;
  - in_ready = 0 while rst_n is low;
  - all in-flight transactions are discarded, including reset asserted mid-operation;
  - first accept is possible in the cycle after rst_n goes high.
- STAGES = 1: a single registered stage, latency 1.
- Modular wrap: the sum is taken mod 2^WIDTH. Carry out of the MSB goes to out_cout only.
- Result fields are undefined-free. When out_valid = 0, outputs hold their last value (0 after reset).

Optional Feature:
- Macro name: CLA_OVF_EN.
- Defined:
  - out_ovf is present.
  - out_ovf = (a[MSB] == b_eff[MSB]) & (sum[MSB] != a[MSB]).
  - It is registered alongside out_sum, with the same latency and stall behaviour, and resets to 0.
- Not defined:
  - out_ovf port is absent.
  - No MSB sign bits are carried through the pipeline.

Test Plan:
- Reset: WIDTH=16, GPS=1. Hold rst_n=0 for 2 cycles with in_valid=1 → out_valid=0, out_sum=0x0000, in_ready=0. One cycle after release, in_ready=1.
- Full carry chain: A=0xFFFF, B=0x0001, cin=0, sub=0, out_ready=1 → exactly 4 cycles later out_sum=0x0000, out_cout=1. Repeat with GPS=2 → latency 2, same result.
- Subtract: A=0x0005, B=0x0007, sub=1 → out_sum=0xFFFE, out_cout=0. A=0x0007, B=0x0005 → 0x0002, out_cout=1.
- Backpressure: issue 4 back-to-back adds (1+1, 2+2, 3+3, 4+4) with out_ready=0 → out_sum=0x0002 held stable with out_valid=1 and in_ready=0. Raise out_ready → 0x0002, 0x0004, 0x0006, 0x0008 on consecutive cycles, none lost.
- Overflow (CLA_OVF_EN): 0x7FFF+0x0001 → 0x8000, out_ovf=1. 0x8000-0x0001 → 0x7FFF, out_ovf=1. 0x0001+0x0001 → out_ovf=0.
- Reset mid-flight: accept 2 transactions, assert rst_n=0 for 1 cycle before either emerges → neither ever appears on the output, out_valid=0. Next accepted transaction has normal latency.
